// File: rtl/display_shift_sequencer.sv
// Serialises one captured frame of 7-segment codes plus decimal points onto a
// '595-style shift/latch chain. Optional macro: DISPLAY_COMMON_ANODE_EN.
module display_shift_sequencer #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    busy,
  output logic                    done,
  output logic                    serial_data,
  output logic                    serial_clk,
  output logic                    serial_latch
);

  localparam int NUM_BITS = 8 * NUM_DIGITS;
  localparam int DIV_W    = $clog2(CLK_DIV) + 1;
  localparam int BIT_W    = $clog2(NUM_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_LO  = 3'd1,
    SHIFT_HI  = 3'd2,
    LATCH_GAP = 3'd3,
    LATCH     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [DIV_W-1:0]      div_cnt, div_next;
  logic [BIT_W-1:0]      bit_cnt, bit_next;
  logic [NUM_BITS-1:0]   frame, frame_in;
  logic                  capture;
  logic                  phase_end;

  // Frame buffer is stored in transmit order: bit 0 is the first bit shifted.
  always_comb begin
    frame_in = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      frame_in[(NUM_DIGITS-1-k)*8 +: 8] = {dp_in[k], seg_in[7*k +: 7]};
    end
`ifdef DISPLAY_COMMON_ANODE_EN
    frame_in = ~frame_in;
`else
    frame_in = frame_in;
`endif
  end

  assign phase_end = (div_cnt == DIV_LAST);

  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        div_next = '0;
        bit_next = '0;
        if (start) begin
          capture    = 1'b1;
          state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          div_next   = '0;
          state_next = SHIFT_HI;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          div_next = '0;
          if (bit_cnt == BIT_LAST) begin
            state_next = LATCH_GAP;
          end else begin
            bit_next   = bit_cnt + BIT_W'(1);
            state_next = SHIFT_LO;
          end
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      LATCH_GAP: begin
        if (phase_end) begin
          div_next   = '0;
          state_next = LATCH;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      LATCH: begin
        if (phase_end) begin
          div_next   = '0;
          state_next = DONE;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        div_next   = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Board-facing pins are registered from the state one cycle behind it, so
  // the chain sees glitch-free edges; busy spans capture through the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      frame        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_data  <= 1'b0;
      serial_clk   <= 1'b0;
      serial_latch <= 1'b0;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      bit_cnt <= bit_next;
      if (capture) begin
        frame <= frame_in;
      end
      busy         <= (state_next != IDLE) || (state == DONE);
      done         <= (state == DONE);
      serial_clk   <= (state == SHIFT_HI);
      serial_latch <= (state == LATCH);
      serial_data  <= ((state == SHIFT_LO) || (state == SHIFT_HI)) ? frame[bit_cnt] : 1'b0;
    end
  end

endmodule

// File: doc/display_shift_sequencer.md
Name: display_shift_sequencer

Overview:
Front-end sequencer for the clock's LED display path. On a start request it captures one 7-segment code plus decimal point per digit, then serialises them onto a chained external shift-register/latch interface (data, shift clock, latch strobe), LSB first. It sits between the time-to-segment decoder and the board-level '595-style digit shift chain, and reports busy/done to the display refresh logic.

Parameters:
NUM_DIGITS, 4, number of chained digits (>=1)
CLK_DIV, 4, system clocks per half serial_clk period (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request a display update; sampled only in IDLE
seg_in  input  7*NUM_DIGITS  segment codes; digit k at [7k+6:7k], bit0 = segment a
dp_in  input  NUM_DIGITS  decimal point per digit; bit k = digit k
busy  output  1  high from the cycle after start is accepted through DONE
done  output  1  one-cycle pulse when the frame has been latched
serial_data  output  1  serial bit to the shift chain
serial_clk  output  1  shift clock; chain samples serial_data on the rising edge
serial_latch  output  1  storage-register latch strobe, active high

Behaviour:
- Reset (synchronous, active-high), and state IDLE: busy=0, done=0, serial_data=0, serial_clk=0, serial_latch=0. Bit, digit and divider counters are cleared.
- Reset asserted mid-frame: all outputs return to 0 at the next edge and the state is IDLE. No latch pulse is issued; the partial frame is abandoned.
- Capture: on the edge where state=IDLE and start=1, seg_in and dp_in are registered into a frame buffer.
  - The inputs may change freely afterwards.
  - busy rises and the state becomes SHIFT_LO.
  - serial_data presents the first bit.
- Bit order:
  - Digits are sent from NUM_DIGITS-1 down to 0.
  - Within a digit, eight bits are sent: segments a..g (bit0..bit6), then dp.
  - Total bits per frame: 8*NUM_DIGITS.
- SHIFT_LO: serial_clk=0 for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: serial_clk=1 for CLK_DIV cycles. At its end:
  - If more bits remain, serial_data advances to the next bit and the state returns to SHIFT_LO. serial_data changes only at the start of a low phase, giving CLK_DIV cycles of setup and hold.
  - After the last bit, the state goes to LATCH_GAP.
- LATCH_GAP: serial_clk=0, serial_data=0, for CLK_DIV cycles.
- LATCH: serial_latch=1 for CLK_DIV cycles.
- DONE: one cycle with done=1 and busy=1, then IDLE (busy=0).
- Latency: start is sampled at edge N; done is high for the cycle following edge N+1+(16*NUM_DIGITS+2)*CLK_DIV. With defaults this is edge N+265.
- start while busy is ignored and not queued. start held high continuously produces back-to-back frames, with one IDLE cycle between DONE and the next capture.
- The divider counter is $clog2(CLK_DIV)+1 bits wide and compares against CLK_DIV-1. CLK_DIV=1 yields single-cycle phases.
- The bit counter is wide enough to hold 8*NUM_DIGITS-1. There is no wrap-around within a frame.

Optional Feature:
Macro: DISPLAY_COMMON_ANODE_EN
- Defined: every captured segment and dp bit is inverted at capture time (active-low LEDs). serial_data still idles at 0 in IDLE, LATCH_GAP and reset.
- Undefined: bits are shifted exactly as captured (active-high).

Test Plan:
- Reset: assert reset 3 cycles at any point, including mid-frame at bit 13 -> all outputs 0 on the next edge; no serial_latch pulse; the next start runs a full frame.
- Single frame, NUM_DIGITS=4, CLK_DIV=2, input "12.34" (seg 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66; dp on digit 2) -> 32 rising serial_clk edges sampling, in order: 0x66 then dp0, 0x4F then dp0, 0x5B then dp1, 0x06 then dp0, each LSB first; serial_latch high 2 cycles; done 133 cycles after the start edge.
- Input stability: change seg_in/dp_in every cycle after start is accepted -> the shifted bits equal the values captured at the start edge.
- start asserted during busy, on random cycles -> ignored; exactly one done pulse per accepted start. start held high -> frames back-to-back with exactly one IDLE cycle between them.
- CLK_DIV=1, NUM_DIGITS=1, seg 7'h7F, dp 1 -> serial_clk toggles every cycle; 8 rising edges all sampling 1; done 19 cycles after the start edge.
- DISPLAY_COMMON_ANODE_EN defined, seg 7'h06, dp 0, NUM_DIGITS=1 -> sampled bits 1,0,0,1,1,1,1,1; serial_data is 0 outside the shift phases.
